// File: rtl/grid_renderer.sv
// Board-to-pixel renderer: snapshots the cell-code board, maps each pixel request to an RGB565
// colour through a two-stage pipeline. The palette is writable at run time. Optional grid lines
// and a blinking cursor outline are supported.
module grid_renderer #(
  parameter int unsigned COLS         = 8,
  parameter int unsigned ROWS         = 8,
  parameter int unsigned CODE_W       = 5,
  parameter int unsigned CELL_SHIFT   = 4,
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned Y_OFFSET     = 16,
  parameter logic [15:0] BG_COLOR     = 16'h0000,
  parameter logic [15:0] LINE_COLOR   = 16'h4208,
  parameter logic [15:0] CURSOR_COLOR = 16'hFFFF,
  parameter int unsigned BLINK_FRAMES = 15,
  localparam int unsigned ColW        = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int unsigned RowW        = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ROWS*COLS*CODE_W-1:0]   board_flat_i,
  input  logic                          board_load_i,
  input  logic                          pix_req_i,
  input  logic [ADDR_W-1:0]             pix_x_i,
  input  logic [ADDR_W-1:0]             pix_y_i,
  output logic                          pix_valid_o,
  output logic [15:0]                   pix_data_o,
  input  logic                          pal_we_i,
  input  logic [CODE_W-1:0]             pal_addr_i,
  input  logic [15:0]                   pal_wdata_i,
  input  logic                          show_lines_i,
  input  logic                          cursor_en_i,
  input  logic [ColW-1:0]               cursor_col_i,
  input  logic [RowW-1:0]               cursor_row_i,
  input  logic                          frame_tick_i
);

  localparam int unsigned PalDepth = 2 ** CODE_W;
  localparam int unsigned XEnd     = COLS << CELL_SHIFT;
  localparam int unsigned YEnd     = Y_OFFSET + (ROWS << CELL_SHIFT);
  localparam int unsigned BlinkW   = $clog2(BLINK_FRAMES + 1);

  function automatic logic [15:0] pal_default(int unsigned idx);
    case (idx)
      10:      pal_default = 16'hFCC0;
      16:      pal_default = 16'hFAAC;
      17:      pal_default = 16'h8760;
      18:      pal_default = 16'h351F;
      default: pal_default = 16'h0000;
    endcase
  endfunction

  logic [ROWS*COLS*CODE_W-1:0] board_q;
  logic [15:0]                 pal_q [PalDepth];
  logic                        blink_on_q, blink_on_d;
  logic [BlinkW-1:0]           blink_cnt_q, blink_cnt_d;

  logic                        s1_valid_q, s1_in_win_q, s1_border_q, s1_cursor_q;
  logic [CODE_W-1:0]           s1_code_q;
  logic                        s1_in_win_d, s1_border_d, s1_cursor_d;
  logic [CODE_W-1:0]           s1_code_d;

  logic                        pix_valid_q;
  logic [15:0]                 pix_data_q, pix_data_d;

  // Extra MSB keeps rows above the board from wrapping into the window.
  logic [ADDR_W:0]             dy;
  logic [ADDR_W-1:0]           col;
  logic [ADDR_W:0]             row;
  logic [CELL_SHIFT-1:0]       lx, ly;
  int unsigned                 cell_idx;

  assign dy  = {1'b0, pix_y_i} - (ADDR_W + 1)'(Y_OFFSET);
  assign col = pix_x_i >> CELL_SHIFT;
  assign row = dy >> CELL_SHIFT;
  assign lx  = pix_x_i[CELL_SHIFT-1:0];
  assign ly  = dy[CELL_SHIFT-1:0];

  // Stage 1 decode: window test, cell lookup in the snapshot, border and cursor hit.
  always_comb begin
    s1_in_win_d = (32'(pix_x_i) < XEnd) && (32'(pix_y_i) >= Y_OFFSET) && (32'(pix_y_i) < YEnd);
    cell_idx    = s1_in_win_d ? (32'(row) * COLS + 32'(col)) : 0;
    s1_code_d   = board_q[cell_idx*CODE_W +: CODE_W];
    s1_border_d = (lx == '0) || (lx == '1) || (ly == '0) || (ly == '1);
    s1_cursor_d = cursor_en_i && (32'(cursor_col_i) < COLS) && (32'(cursor_row_i) < ROWS) &&
                  (32'(col) == 32'(cursor_col_i)) && (32'(row) == 32'(cursor_row_i));
  end

  // Stage 2 colour select; the palette is read here so same-edge writes are visible.
  always_comb begin
    if (!s1_in_win_q) begin
      pix_data_d = BG_COLOR;
    end else if (s1_cursor_q && s1_border_q && blink_on_q) begin
      pix_data_d = CURSOR_COLOR;
    end else if (show_lines_i && s1_border_q) begin
      pix_data_d = LINE_COLOR;
    end else begin
      pix_data_d = pal_q[s1_code_q];
    end
  end

  // Blink counter: toggles the cursor every BLINK_FRAMES frame ticks.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (frame_tick_i) begin
      if (32'(blink_cnt_q) == BLINK_FRAMES - 1) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Board snapshot, palette storage and blink state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      board_q     <= '0;
      blink_on_q  <= 1'b1;
      blink_cnt_q <= '0;
      for (int i = 0; i < PalDepth; i++) begin
        pal_q[i] <= pal_default(i);
      end
    end else begin
      blink_on_q  <= blink_on_d;
      blink_cnt_q <= blink_cnt_d;
      if (board_load_i) begin
        board_q <= board_flat_i;
      end
      if (pal_we_i) begin
        pal_q[pal_addr_i] <= pal_wdata_i;
      end
    end
  end

  // Pipeline registers; payload only moves with a valid request, output holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_in_win_q <= 1'b0;
      s1_border_q <= 1'b0;
      s1_cursor_q <= 1'b0;
      s1_code_q   <= '0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
    end else begin
      s1_valid_q  <= pix_req_i;
      pix_valid_q <= s1_valid_q;
      if (pix_req_i) begin
        s1_in_win_q <= s1_in_win_d;
        s1_border_q <= s1_border_d;
        s1_cursor_q <= s1_cursor_d;
        s1_code_q   <= s1_code_d;
      end
      if (s1_valid_q) begin
        pix_data_q <= pix_data_d;
      end
    end
  end

  assign pix_valid_o = pix_valid_q;
  assign pix_data_o  = pix_data_q;

endmodule

// File: tb/tb_grid_renderer.sv
// Directed bench for grid_renderer: latency, window, streaming, palette/board timing, cursor,
// blink and mid-pipeline reset.
module tb_grid_renderer;
  localparam int BW = 8 * 8 * 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [BW-1:0] board;
  logic          board_load, pix_req, pal_we, show_lines, cursor_en, frame_tick;
  logic [7:0]    pix_x, pix_y;
  logic          pix_valid;
  logic [15:0]   pix_data;
  logic [4:0]    pal_addr;
  logic [15:0]   pal_wdata;
  logic [2:0]    cursor_col, cursor_row;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  grid_renderer #(.BLINK_FRAMES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .board_flat_i (board),
    .board_load_i (board_load),
    .pix_req_i    (pix_req),
    .pix_x_i      (pix_x),
    .pix_y_i      (pix_y),
    .pix_valid_o  (pix_valid),
    .pix_data_o   (pix_data),
    .pal_we_i     (pal_we),
    .pal_addr_i   (pal_addr),
    .pal_wdata_i  (pal_wdata),
    .show_lines_i (show_lines),
    .cursor_en_i  (cursor_en),
    .cursor_col_i (cursor_col),
    .cursor_row_i (cursor_row),
    .frame_tick_i (frame_tick)
  );

  function automatic logic [15:0] def_color(int code);
    case (code)
      10:      def_color = 16'hFCC0;
      16:      def_color = 16'hFAAC;
      17:      def_color = 16'h8760;
      18:      def_color = 16'h351F;
      default: def_color = 16'h0000;
    endcase
  endfunction

  task automatic set_cell(input int k, input logic [4:0] code);
    board[k*5 +: 5] = code;
  endtask

  task automatic load_board();
    @(negedge clk);
    board_load = 1'b1;
    @(negedge clk);
    board_load = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  // Issue one request and return the output two edges later.
  task automatic send(input int x, input int y, output logic v, output logic [15:0] d);
    @(negedge clk);
    pix_req = 1'b1;
    pix_x   = 8'(x);
    pix_y   = 8'(y);
    @(negedge clk);
    pix_req = 1'b0;
    @(negedge clk);
    v = pix_valid;
    d = pix_data;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    board = '0; board_load = 0; pix_req = 0; pix_x = 0; pix_y = 0; pal_we = 0;
    pal_addr = 0; pal_wdata = 0; show_lines = 0; cursor_en = 0; cursor_col = 0;
    cursor_row = 0; frame_tick = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (pix_valid !== 1'b0 || pix_data !== 16'h0000) begin
      failures++;
      $display("FAIL reset valid=%b data=%h expected valid=0 data=0000", pix_valid, pix_data);
    end
  endtask

  task automatic test_basic();
    logic v;
    logic [15:0] d;
    set_cell(0, 5'd10);
    load_board();
    @(negedge clk);
    pix_req = 1; pix_x = 0; pix_y = 16;
    @(negedge clk);
    pix_req = 0;
    checks++;
    if (pix_valid !== 1'b0) begin
      failures++;
      $display("FAIL latency_early valid=%b expected 0", pix_valid);
    end
    @(negedge clk);
    checks++;
    if (pix_valid !== 1'b1 || pix_data !== 16'hFCC0) begin
      failures++;
      $display("FAIL basic_cell0 valid=%b data=%h expected valid=1 data=FCC0", pix_valid, pix_data);
    end
    @(negedge clk);
    checks++;
    if (pix_valid !== 1'b0 || pix_data !== 16'hFCC0) begin
      failures++;
      $display("FAIL hold valid=%b data=%h expected valid=0 data=FCC0", pix_valid, pix_data);
    end
    send(5, 15, v, d);
    checks++;
    if (v !== 1'b1 || d !== 16'h0000) begin
      failures++;
      $display("FAIL above_window valid=%b data=%h expected valid=1 data=0000", v, d);
    end
    send(0, 144, v, d);
    checks++;
    if (v !== 1'b1 || d !== 16'h0000) begin
      failures++;
      $display("FAIL below_window valid=%b data=%h expected valid=1 data=0000", v, d);
    end
  endtask

  task automatic test_stream();
    logic v;
    logic [15:0] d, exp;
    for (int c = 0; c < 8; c++) set_cell(8 + c, 5'(16 + c % 3));
    load_board();
    for (int i = 0; i < 130; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        exp = def_color(16 + ((i - 2) >> 4) % 3);
        checks++;
        if (pix_valid !== 1'b1 || pix_data !== exp) begin
          failures++;
          $display("FAIL stream x=%0d valid=%b data=%h expected valid=1 data=%h",
                   i - 2, pix_valid, pix_data, exp);
        end
      end
      if (i < 128) begin
        pix_req = 1; pix_x = 8'(i); pix_y = 40;
      end else begin
        pix_req = 0;
      end
    end
    @(negedge clk);
    checks++;
    if (pix_valid !== 1'b0) begin
      failures++;
      $display("FAIL stream_end valid=%b expected 0", pix_valid);
    end
    send(128, 40, v, d);
    checks++;
    if (v !== 1'b1 || d !== 16'h0000) begin
      failures++;
      $display("FAIL right_of_window valid=%b data=%h expected valid=1 data=0000", v, d);
    end
  endtask

  task automatic test_palette();
    // Cell 9 holds code 17; first request precedes the write, second shares its edge.
    @(negedge clk);
    pix_req = 1; pix_x = 20; pix_y = 40;
    @(negedge clk);
    pal_we = 1; pal_addr = 17; pal_wdata = 16'h07E0;
    @(negedge clk);
    pix_req = 0; pal_we = 0;
    checks++;
    if (pix_valid !== 1'b1 || pix_data !== 16'h8760) begin
      failures++;
      $display("FAIL pal_before_write valid=%b data=%h expected valid=1 data=8760",
               pix_valid, pix_data);
    end
    @(negedge clk);
    checks++;
    if (pix_valid !== 1'b1 || pix_data !== 16'h07E0) begin
      failures++;
      $display("FAIL pal_same_edge valid=%b data=%h expected valid=1 data=07E0",
               pix_valid, pix_data);
    end
  endtask

  task automatic test_board_load();
    set_cell(9, 5'd16);
    load_board();
    @(negedge clk);
    set_cell(9, 5'd18);
    board_load = 1; pix_req = 1; pix_x = 20; pix_y = 40;
    @(negedge clk);
    board_load = 0;
    @(negedge clk);
    pix_req = 0;
    checks++;
    if (pix_valid !== 1'b1 || pix_data !== 16'hFAAC) begin
      failures++;
      $display("FAIL load_same_edge valid=%b data=%h expected valid=1 data=FAAC",
               pix_valid, pix_data);
    end
    @(negedge clk);
    checks++;
    if (pix_valid !== 1'b1 || pix_data !== 16'h351F) begin
      failures++;
      $display("FAIL load_after valid=%b data=%h expected valid=1 data=351F",
               pix_valid, pix_data);
    end
  endtask

  task automatic test_cursor();
    logic v;
    logic [15:0] d;
    set_cell(26, 5'd18);
    load_board();
    cursor_en = 1; cursor_col = 2; cursor_row = 3;
    send(32, 64, v, d);
    checks++;
    if (d !== 16'hFFFF) begin
      failures++;
      $display("FAIL cursor_on data=%h expected FFFF", d);
    end
    send(40, 72, v, d);
    checks++;
    if (d !== 16'h351F) begin
      failures++;
      $display("FAIL cursor_interior data=%h expected 351F", d);
    end
    tick();
    send(32, 64, v, d);
    checks++;
    if (d !== 16'hFFFF) begin
      failures++;
      $display("FAIL cursor_one_tick data=%h expected FFFF", d);
    end
    tick();
    send(32, 64, v, d);
    checks++;
    if (d !== 16'h351F) begin
      failures++;
      $display("FAIL cursor_blink_off data=%h expected 351F", d);
    end
    show_lines = 1;
    send(32, 64, v, d);
    checks++;
    if (d !== 16'h4208) begin
      failures++;
      $display("FAIL cursor_off_lines data=%h expected 4208", d);
    end
    send(40, 72, v, d);
    checks++;
    if (d !== 16'h351F) begin
      failures++;
      $display("FAIL lines_interior data=%h expected 351F", d);
    end
    show_lines = 0;
    tick();
    tick();
    send(32, 64, v, d);
    checks++;
    if (d !== 16'hFFFF) begin
      failures++;
      $display("FAIL cursor_blink_back data=%h expected FFFF", d);
    end
    cursor_en = 0;
    send(32, 64, v, d);
    checks++;
    if (d !== 16'h351F) begin
      failures++;
      $display("FAIL cursor_disabled data=%h expected 351F", d);
    end
    // Leave blink off so the reset test can see it restored.
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    logic v;
    logic [15:0] d;
    @(negedge clk);
    pix_req = 1; pix_x = 20; pix_y = 40;
    @(negedge clk);
    pix_x = 69;
    rst = 1;
    #1;
    checks++;
    if (pix_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_assert valid=%b expected 0", pix_valid);
    end
    @(negedge clk);
    pix_req = 0;
    checks++;
    if (pix_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_held valid=%b expected 0", pix_valid);
    end
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    checks++;
    if (pix_valid !== 1'b0 || pix_data !== 16'h0000) begin
      failures++;
      $display("FAIL rst_release valid=%b data=%h expected valid=0 data=0000", pix_valid, pix_data);
    end
    send(69, 40, v, d);
    checks++;
    if (v !== 1'b1 || d !== 16'h0000) begin
      failures++;
      $display("FAIL snapshot_cleared valid=%b data=%h expected valid=1 data=0000", v, d);
    end
    load_board();
    send(69, 40, v, d);
    checks++;
    if (d !== 16'h8760) begin
      failures++;
      $display("FAIL palette_restored data=%h expected 8760", d);
    end
    cursor_en = 1; cursor_col = 2; cursor_row = 3;
    send(32, 64, v, d);
    checks++;
    if (d !== 16'hFFFF) begin
      failures++;
      $display("FAIL blink_restored data=%h expected FFFF", d);
    end
    cursor_en = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stream();
    test_palette();
    test_board_load();
    test_cursor();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/grid_renderer.md
Name: grid_renderer

Overview:
- Parametrised board-to-pixel renderer for the LCD frame path.
- Snapshots the flattened cell-code board from the game manager and maps each requested pixel address to RGB565 through a 2-stage pipeline.
- Palette is run-time writable; optional cell grid lines; blinking cursor outline driven by frame ticks.
- Sits between the game manager and the display RAM writer.

Parameters:
- COLS, 8, board columns
- ROWS, 8, board rows
- CODE_W, 5, bits per cell code; palette depth 2^CODE_W
- CELL_SHIFT, 4, log2 of cell size in pixels (16x16 cells)
- ADDR_W, 8, pixel address width
- Y_OFFSET, 16, first board pixel row
- BG_COLOR, 16'h0000, colour outside the board window
- LINE_COLOR, 16'h4208, grid line colour
- CURSOR_COLOR, 16'hFFFF, cursor outline colour
- BLINK_FRAMES, 15, frame_tick pulses per cursor blink half-period (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- board_flat  in  ROWS*COLS*CODE_W  cell codes; cell k at [k*CODE_W +: CODE_W], k = row*COLS+col
- board_load  in  1  snapshot board_flat at this edge
- pix_req  in  1  pixel request strobe
- pix_x  in  ADDR_W  request column
- pix_y  in  ADDR_W  request row
- pix_valid  out  1  pix_data valid for a request
- pix_data  out  16  RGB565 result
- pal_we  in  1  palette write enable
- pal_addr  in  CODE_W  palette entry index
- pal_wdata  in  16  palette write data
- show_lines  in  1  draw LINE_COLOR on cell borders
- cursor_en  in  1  enable cursor outline
- cursor_col  in  clog2(COLS)  cursor cell column
- cursor_row  in  clog2(ROWS)  cursor cell row
- frame_tick  in  1  one-cycle pulse per display frame

Behaviour:
- Reset: pix_valid=0, pix_data=0, snapshot all zeros, blink_on=1, blink_cnt=0. Palette defaults: entry 10=16'hFCC0, 16=16'hFAAC, 17=16'h8760, 18=16'h351F, all others 16'h0000.
- Snapshot: on an edge with board_load=1, snapshot<=board_flat. Requests sampled at that same edge use the old snapshot. Later requests use the new one.
- Stage 1 (edge where pix_req=1):
  - Register in_win = (pix_x < COLS<<CELL_SHIFT) && (pix_y >= Y_OFFSET) && (pix_y < Y_OFFSET + ROWS<<CELL_SHIFT).
  - col = pix_x>>CELL_SHIFT; row = (pix_y-Y_OFFSET)>>CELL_SHIFT. Subtraction uses ADDR_W+1 bits, so no wrap when pix_y<Y_OFFSET.
  - Register the cell code from the snapshot.
  - border = local x or local y equals 0 or 2^CELL_SHIFT-1.
  - is_cursor = cursor_en && row==cursor_row && col==cursor_col.
- Stage 2: output priority:
  - !in_win -> BG_COLOR
  - is_cursor && border && blink_on -> CURSOR_COLOR
  - show_lines && border -> LINE_COLOR
  - else palette[code]
- Latency: pix_valid=1 exactly 2 edges after the request edge. Otherwise pix_valid=0 and pix_data holds its last value. Back-to-back requests every cycle are accepted with no bubbles; there is no backpressure.
- Palette timing:
  - Write on edge E with pal_we=1.
  - Palette is read in stage 2, so a request sampled at edge E already sees the new value.
  - A request sampled at edge E-1 sees the old value.
- Blink: on each frame_tick, blink_cnt++. When blink_cnt reaches BLINK_FRAMES-1 on a tick, blink_cnt<=0 and blink_on toggles.
- Cursor coordinates outside the board (cursor_col>=COLS or cursor_row>=ROWS): no cursor drawn.
- Codes with no palette write keep their reset entry; code 0 renders 16'h0000 by default.
- Reset mid-pipeline: in-flight requests are discarded and pix_valid=0 on the first edge after rst deasserts.

Test Plan:
- Reset, then request (0,16) with cell 0 code 10 -> after 2 cycles pix_valid=1, pix_data=16'hFCC0. Request (5,15) -> BG_COLOR 16'h0000.
- Stream 128 consecutive requests across row y=40 (board row 1), codes 16/17/18 alternating by column -> pix_valid high 128 cycles, each 16-pixel run FAAC/8760/351F, no gaps.
- pal_we addr 17 data 16'h07E0 on the same cycle as a request to a code-17 cell -> 16'h07E0. Request one cycle earlier -> 16'h8760.
- board_load with cell 9 changing 16->18 on the same edge as a request into cell 9 -> FAAC; the next request -> 351F.
- cursor_en=1 at cell (2,3), BLINK_FRAMES=2: pixel (32,64) -> FFFF. After 2 frame_ticks same pixel -> palette colour, or LINE_COLOR if show_lines=1. Interior pixel (40,72) -> palette colour always.
- Assert rst with 2 requests in flight -> pix_valid=0 throughout. Palette reverts to defaults and snapshot to zeros (in-window pixels render 16'h0000).
